// File: rtl/crossbar4_req_responder_if.sv
// ---------------------------------------------------------------------------
// crossbar4_req_responder_if
// Request/acknowledge bundle between the four crossbar request sources
// (master side) and the round-robin responder (slave side).
// ---------------------------------------------------------------------------
interface crossbar4_req_responder_if;

    logic [3:0] req;         // per-port request level
    logic [3:0] ack;         // per-port acknowledge, one-hot or zero
    logic [1:0] grant_id;    // current or last granted port
    logic       busy;        // responder is not idle
    logic [3:0] port_reset;  // one-cycle abort pulse to a timed-out port

    // Request sources drive req and watch everything else.
    modport master (
        output req,
        input  ack,
        input  grant_id,
        input  busy,
        input  port_reset
    );

    // The responder samples req and drives the handshake outputs.
    modport slave (
        input  req,
        output ack,
        output grant_id,
        output busy,
        output port_reset
    );

endinterface : crossbar4_req_responder_if

// File: rtl/crossbar4_req_responder.sv
// ---------------------------------------------------------------------------
// crossbar4_req_responder
// Responder end of the 4-port crossbar req/ack handshake. Grants one port at
// a time, round-robin, and aborts a port that holds its grant for HOLD_MAX
// cycles by pulsing its port_reset line.
//
// Optional build macro: CROSSBAR_RESP_STATS_EN
//   When defined, adds grant_cnt (completed grants per port) and abort_cnt
//   (timeout aborts) saturating statistics outputs.
//
// Parameters:
//   HOLD_MAX - cycles ack may stay high before abort; 0 disables the timeout.
//              A value above 2**CNT_W can never be reached by the saturating
//              hold counter, which also leaves the timeout inactive.
//   CNT_W    - width of the hold counter and of each statistics counter.
// ---------------------------------------------------------------------------
module crossbar4_req_responder #(
    parameter int unsigned HOLD_MAX = 64,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      hard_reset,
    crossbar4_req_responder_if.slave  bus
`ifdef CROSSBAR_RESP_STATS_EN
    ,
    output logic [4*CNT_W-1:0]        grant_cnt,
    output logic [CNT_W-1:0]          abort_cnt
`endif
);

    // -----------------------------------------------------------------------
    // Types and constants
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2,
        ABORT   = 2'd3
    } state_e;

    localparam bit               TIMEOUT_EN = (HOLD_MAX != 0);
    // Last hold count value at which the grant is still legal.
    localparam int unsigned      HOLD_LAST  = TIMEOUT_EN ? HOLD_MAX - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e           state_q,      state_d;
    logic [3:0]       ack_q,        ack_d;
    logic [1:0]       grant_id_q,   grant_id_d;
    logic             busy_q,       busy_d;
    logic [3:0]       port_reset_q, port_reset_d;
    logic [1:0]       rr_ptr_q,     rr_ptr_d;
    logic [CNT_W-1:0] hold_cnt_q,   hold_cnt_d;

    // Arbitration result and handshake events.
    logic             win_valid;
    logic [1:0]       win_id;
    logic             owner_req;
    logic             hold_at_last;
    logic             grant_done;   // entering RELEASE this cycle
    logic             abort_start;  // entering ABORT this cycle

    // -----------------------------------------------------------------------
    // Round-robin winner: first requesting port scanning upward from rr_ptr.
    // -----------------------------------------------------------------------
    always_comb begin
        win_valid = 1'b0;
        win_id    = rr_ptr_q;
        // Scan from the farthest offset down so the nearest requester wins.
        for (int i = 3; i >= 0; i--) begin
            if (bus.req[rr_ptr_q + 2'(i)]) begin
                win_valid = 1'b1;
                win_id    = rr_ptr_q + 2'(i);
            end
        end
    end

    // Request line of the port currently holding (or last holding) the grant.
    assign owner_req    = bus.req[grant_id_q];
    assign hold_at_last = TIMEOUT_EN && (32'(hold_cnt_q) == HOLD_LAST);

    // -----------------------------------------------------------------------
    // Next-state and registered-output decode.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves a combinational output unassigned and infers a latch.
        state_d      = state_q;
        ack_d        = ack_q;
        grant_id_d   = grant_id_q;
        port_reset_d = '0;
        rr_ptr_d     = rr_ptr_q;
        hold_cnt_d   = hold_cnt_q;
        grant_done   = 1'b0;
        abort_start  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d    = GRANT;
                    ack_d      = 4'b0001 << win_id;
                    grant_id_d = win_id;
                    hold_cnt_d = '0;
                end
            end

            GRANT: begin
                if (!owner_req) begin
                    // Normal completion, including a req that fell while
                    // ack was rising.
                    state_d    = RELEASE;
                    ack_d      = '0;
                    grant_done = 1'b1;
                end else if (hold_at_last) begin
                    state_d      = ABORT;
                    ack_d        = '0;
                    port_reset_d = 4'b0001 << grant_id_q;
                    abort_start  = 1'b1;
                end else if (hold_cnt_q != CNT_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            RELEASE: begin
                // Mandatory ack-low cycle; no arbitration here.
                state_d  = IDLE;
                rr_ptr_d = grant_id_q + 2'd1;
            end

            ABORT: begin
                // Stay blocked until the aborted port lets go of req.
                if (!owner_req) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_id_q + 2'd1;
                end
            end

            default: begin
                state_d = IDLE;
                ack_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // -----------------------------------------------------------------------
    // State and output registers with synchronous reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (hard_reset) begin
            state_q      <= IDLE;
            ack_q        <= '0;
            grant_id_q   <= '0;
            busy_q       <= 1'b0;
            port_reset_q <= '0;
            rr_ptr_q     <= '0;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            grant_id_q   <= grant_id_d;
            busy_q       <= busy_d;
            port_reset_q <= port_reset_d;
            rr_ptr_q     <= rr_ptr_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.busy       = busy_q;
    assign bus.port_reset = port_reset_q;

`ifdef CROSSBAR_RESP_STATS_EN
    // -----------------------------------------------------------------------
    // Optional statistics: completed grants per port and abort count.
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] grant_cnt_q [4];
    logic [CNT_W-1:0] abort_cnt_q;

    // Saturating counters, bumped on entry to RELEASE / ABORT.
    always_ff @(posedge clk) begin
        if (hard_reset) begin
            // NOTE: this small register array is reset explicitly because the
            // counts must read zero after hard_reset; large storage arrays
            // would normally be left unreset.
            for (int i = 0; i < 4; i++) begin
                grant_cnt_q[i] <= '0;
            end
            abort_cnt_q <= '0;
        end else begin
            if (grant_done && (grant_cnt_q[grant_id_q] != CNT_MAX)) begin
                grant_cnt_q[grant_id_q] <= grant_cnt_q[grant_id_q] + 1'b1;
            end
            if (abort_start && (abort_cnt_q != CNT_MAX)) begin
                abort_cnt_q <= abort_cnt_q + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_grant_cnt
        assign grant_cnt[g*CNT_W +: CNT_W] = grant_cnt_q[g];
    end

    assign abort_cnt = abort_cnt_q;
`endif

    // -----------------------------------------------------------------------
    // Handshake invariants.
    // -----------------------------------------------------------------------
    a_ack_onehot0 : assert property (
        @(posedge clk) disable iff (hard_reset) $onehot0(bus.ack));

    a_prst_onehot0 : assert property (
        @(posedge clk) disable iff (hard_reset) $onehot0(bus.port_reset));

    a_prst_single : assert property (
        @(posedge clk) disable iff (hard_reset)
        (bus.port_reset != 4'b0000) |=> (bus.port_reset == 4'b0000));

    a_ack_prst_excl : assert property (
        @(posedge clk) disable iff (hard_reset)
        !((bus.ack != 4'b0000) && (bus.port_reset != 4'b0000)));

endmodule : crossbar4_req_responder

// File: tb/tb_crossbar4_req_responder.sv
// ---------------------------------------------------------------------------
// tb_crossbar4_req_responder
// Directed scenarios plus a randomized multi-port run checked against a
// transaction-level reference model of the round-robin responder.
// Build with +define+CROSSBAR_RESP_STATS_EN to also check the counters.
// ---------------------------------------------------------------------------
module tb_crossbar4_req_responder;

    localparam int HOLD = 8;
    localparam int CW   = 8;

    logic clk = 1'b0;
    logic hard_reset;
    int   checks = 0;
    int   errors = 0;

    crossbar4_req_responder_if bus ();

`ifdef CROSSBAR_RESP_STATS_EN
    logic [4*CW-1:0] grant_cnt;
    logic [CW-1:0]   abort_cnt;
`endif

    crossbar4_req_responder #(
        .HOLD_MAX (HOLD),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .hard_reset (hard_reset),
        .bus        (bus)
`ifdef CROSSBAR_RESP_STATS_EN
        ,
        .grant_cnt  (grant_cnt),
        .abort_cnt  (abort_cnt)
`endif
    );

    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Reference model: who owns the grant, whether we are in the mandatory
    // release gap or blocked on an aborted port, and how long ack has been up.
    // -----------------------------------------------------------------------
    int         m_owner;     // -1 when nobody holds ack
    bit         m_rel;       // release gap cycle pending
    bit         m_abt;       // waiting for aborted port to drop req
    int         m_ptr;       // round-robin start port
    int         m_last;      // last granted port
    int         m_acks;      // cycles ack has been high for the owner
    logic [3:0] e_ack, e_prst;
    logic [1:0] e_gid;
    logic       e_busy;
    int         e_gcnt [4];
    int         e_acnt;

    always @(posedge clk) begin
        if (hard_reset) begin
            m_owner = -1; m_rel = 0; m_abt = 0; m_ptr = 0; m_last = 0; m_acks = 0;
            e_ack = 4'b0; e_prst = 4'b0; e_gid = 2'b0; e_busy = 1'b0;
            for (int i = 0; i < 4; i++) e_gcnt[i] = 0;
            e_acnt = 0;
        end else begin
            e_prst = 4'b0;
            if (m_rel) begin
                m_rel = 0;
                m_ptr = (m_last + 1) % 4;
            end else if (m_abt) begin
                if (!bus.req[m_last]) begin
                    m_abt = 0;
                    m_ptr = (m_last + 1) % 4;
                end
            end else if (m_owner >= 0) begin
                if (!bus.req[m_owner]) begin
                    if (e_gcnt[m_owner] < (1 << CW) - 1) e_gcnt[m_owner]++;
                    m_owner = -1;
                    m_rel   = 1;
                end else if (HOLD != 0 && m_acks == HOLD) begin
                    e_prst = 4'(1 << m_owner);
                    if (e_acnt < (1 << CW) - 1) e_acnt++;
                    m_owner = -1;
                    m_abt   = 1;
                end else begin
                    m_acks++;
                end
            end else if (bus.req != 4'b0) begin
                bit found;
                found = 0;
                for (int i = 0; i < 4; i++) begin
                    if (!found && bus.req[(m_ptr + i) % 4]) begin
                        found   = 1;
                        m_owner = (m_ptr + i) % 4;
                    end
                end
                m_last = m_owner;
                m_acks = 1;
            end
            e_ack  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
            e_gid  = 2'(m_last);
            e_busy = (m_owner >= 0) || m_rel || m_abt;
        end
    end

    // Hold reset for n cycles with all requests low.
    task automatic do_reset(input int n);
        hard_reset = 1'b1;
        bus.req    = 4'b0;
        repeat (n) @(negedge clk);
        hard_reset = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        hard_reset = 1'b1;
        bus.req    = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.ack !== 4'b0 || bus.busy !== 1'b0 || bus.port_reset !== 4'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d ack=%b busy=%b prst=%b want 0000/0/0000",
                         c, bus.ack, bus.busy, bus.port_reset);
            end
        end
        checks++;
        if (bus.grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_gid got %0d want 0", bus.grant_id);
        end
        hard_reset = 1'b0;
        #1;
        checks++;
        if (bus.ack !== 4'b0) begin
            errors++;
            $display("FAIL reset_release_ack got %b want 0000", bus.ack);
        end
        @(negedge clk);
        checks++;
        if (bus.ack !== 4'b0001 || bus.grant_id !== 2'd0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant ack=%b gid=%0d busy=%b want 0001/0/1",
                     bus.ack, bus.grant_id, bus.busy);
        end
        bus.req = 4'b0;
        @(negedge clk);
        checks++;
        if (bus.ack !== 4'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release ack=%b busy=%b want 0000/1", bus.ack, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b want 0", bus.busy);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_single_port();
        bus.req = 4'b0100;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.ack !== 4'b0100 || bus.grant_id !== 2'd2) begin
                errors++;
                $display("FAIL single_grant cyc%0d ack=%b gid=%0d want 0100/2",
                         c, bus.ack, bus.grant_id);
            end
        end
        bus.req = 4'b0;
        @(negedge clk);
        checks++;
        if (bus.ack !== 4'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_drop ack=%b busy=%b want 0000/1", bus.ack, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.grant_id !== 2'd2) begin
            errors++;
            $display("FAIL single_idle busy=%b gid=%0d want 0/2", bus.busy, bus.grant_id);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_fairness();
        int         order [$];
        int         hc [4];
        bit         gap_ok;
        logic [3:0] prev_ack;
        do_reset(2);
        bus.req  = 4'b1111;
        gap_ok   = 1;
        prev_ack = 4'b0;
        for (int i = 0; i < 4; i++) hc[i] = 0;
        for (int c = 0; c < 80 && order.size() < 5; c++) begin
            @(negedge clk);
            if (bus.ack != 4'b0 && bus.ack != prev_ack) begin
                if (prev_ack != 4'b0) gap_ok = 0;
                for (int p = 0; p < 4; p++) if (bus.ack[p]) order.push_back(p);
            end
            prev_ack = bus.ack;
            for (int p = 0; p < 4; p++) begin
                if (bus.ack[p]) begin
                    hc[p]++;
                    if (hc[p] == 3) bus.req[p] = 1'b0;
                end else if (!bus.req[p]) begin
                    bus.req[p] = 1'b1;
                    hc[p]      = 0;
                end
            end
        end
        checks++;
        if (order.size() != 5) begin
            errors++;
            $display("FAIL fair_count got %0d grants want 5", order.size());
        end
        for (int k = 0; k < order.size(); k++) begin
            checks++;
            if (order[k] != k % 4) begin
                errors++;
                $display("FAIL fair_order idx%0d got port %0d want %0d", k, order[k], k % 4);
            end
        end
        checks++;
        if (!gap_ok) begin
            errors++;
            $display("FAIL fair_gap got back-to-back ack want idle gap");
        end
        bus.req = 4'b0;
        repeat (4) @(negedge clk);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_timeout();
        int cnt;
        do_reset(2);
        bus.req = 4'b0010;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.ack === 4'b0010) cnt++;
            else if (cnt > 0) break;
        end
        checks++;
        if (cnt != HOLD) begin
            errors++;
            $display("FAIL timeout_len got %0d cycles want %0d", cnt, HOLD);
        end
        checks++;
        if (bus.port_reset !== 4'b0010 || bus.ack !== 4'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse prst=%b ack=%b busy=%b want 0010/0000/1",
                     bus.port_reset, bus.ack, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.port_reset !== 4'b0 || bus.ack !== 4'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_after prst=%b ack=%b busy=%b want 0000/0000/1",
                     bus.port_reset, bus.ack, bus.busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.ack !== 4'b0) begin
            errors++;
            $display("FAIL timeout_blocked busy=%b ack=%b want 1/0000", bus.busy, bus.ack);
        end
        bus.req = 4'b0100;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle busy=%b want 0", bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.ack !== 4'b0100) begin
            errors++;
            $display("FAIL timeout_next ack=%b want 0100", bus.ack);
        end
        bus.req = 4'b0;
        repeat (3) @(negedge clk);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_mid_grant();
        do_reset(2);
        bus.req = 4'b1000;
        @(negedge clk);
        checks++;
        if (bus.ack !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_grant ack=%b want 1000", bus.ack);
        end
        hard_reset = 1'b1;
        bus.req    = 4'b1001;
        @(negedge clk);
        checks++;
        if (bus.ack !== 4'b0 || bus.busy !== 1'b0 || bus.grant_id !== 2'd0) begin
            errors++;
            $display("FAIL midrst_clear ack=%b busy=%b gid=%0d want 0000/0/0",
                     bus.ack, bus.busy, bus.grant_id);
        end
        hard_reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ack !== 4'b0001 || bus.grant_id !== 2'd0) begin
            errors++;
            $display("FAIL midrst_next ack=%b gid=%0d want 0001/0", bus.ack, bus.grant_id);
        end
        bus.req = 4'b0;
        repeat (3) @(negedge clk);
    endtask

`ifdef CROSSBAR_RESP_STATS_EN
    // -----------------------------------------------------------------------
    task automatic test_stats();
        bit seen;
        do_reset(2);
        for (int g = 0; g < 3; g++) begin
            bus.req = 4'b0001;
            seen    = 0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                if (bus.ack[0]) seen = 1;
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL stats_grant%0d ack=%b want 0001 within 10 cycles", g, bus.ack);
            end
            bus.req = 4'b0;
            repeat (3) @(negedge clk);
        end
        bus.req = 4'b1000;
        seen    = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus.port_reset[3]) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stats_abort prst=%b want 1000 within 20 cycles", bus.port_reset);
        end
        bus.req = 4'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (grant_cnt[0 +: CW] !== CW'(3) || grant_cnt[3*CW +: CW] !== CW'(0) ||
            abort_cnt !== CW'(1)) begin
            errors++;
            $display("FAIL stats_counts g0=%0d g3=%0d ab=%0d want 3/0/1",
                     grant_cnt[0 +: CW], grant_cnt[3*CW +: CW], abort_cnt);
        end
    endtask
`endif

    // -----------------------------------------------------------------------
    task automatic test_random();
        int hold_left [4];
        bit granted [4];
        do_reset(2);
        for (int p = 0; p < 4; p++) begin
            hold_left[p] = 0;
            granted[p]   = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            checks++;
            if (bus.ack !== e_ack || bus.grant_id !== e_gid || bus.busy !== e_busy ||
                bus.port_reset !== e_prst) begin
                errors++;
                $display("FAIL rand_cyc%0d ack=%b gid=%0d busy=%b prst=%b want %b/%0d/%b/%b",
                         c, bus.ack, bus.grant_id, bus.busy, bus.port_reset,
                         e_ack, e_gid, e_busy, e_prst);
            end
`ifdef CROSSBAR_RESP_STATS_EN
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (grant_cnt[p*CW +: CW] !== CW'(e_gcnt[p])) begin
                    errors++;
                    $display("FAIL rand_gcnt%0d cyc%0d got %0d want %0d",
                             p, c, grant_cnt[p*CW +: CW], e_gcnt[p]);
                end
            end
            checks++;
            if (abort_cnt !== CW'(e_acnt)) begin
                errors++;
                $display("FAIL rand_acnt cyc%0d got %0d want %0d", c, abort_cnt, e_acnt);
            end
`endif
            // Request agents: raise at random, hold a random time after ack.
            for (int p = 0; p < 4; p++) begin
                if (bus.req[p]) begin
                    if (bus.ack[p] && !granted[p]) begin
                        granted[p]   = 1;
                        hold_left[p] = $urandom_range(0, 11);
                    end
                    if (granted[p]) begin
                        if (hold_left[p] == 0) begin
                            bus.req[p] = 1'b0;
                            granted[p] = 0;
                        end else begin
                            hold_left[p]--;
                        end
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.req[p] = 1'b1;
                end
            end
        end
        bus.req = 4'b0;
        repeat (20) @(negedge clk);
    endtask

    // -----------------------------------------------------------------------
    initial begin
        hard_reset = 1'b1;
        bus.req    = 4'b0;
        test_reset();
        test_single_port();
        test_fairness();
        test_timeout();
        test_reset_mid_grant();
`ifdef CROSSBAR_RESP_STATS_EN
        test_stats();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_crossbar4_req_responder

// File: doc/crossbar4_req_responder.md
Name: crossbar4_req_responder

Overview:
- Responder end of the 4-port crossbar request handshake; the counterpart to the crossbar request stimulus generator that drives req[3:0].
- Samples four request lines and grants one port at a time by round-robin over a 4-phase req/ack handshake.
- Aborts a port that holds its grant too long by pulsing a per-port reset.
- Sits between the request sources and the crossbar datapath select logic.

Parameters:
- HOLD_MAX, 64, maximum cycles ack may stay high before abort; 0 disables the timeout.
- CNT_W, 8, width of the hold counter and of each optional statistics counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- hard_reset  input  1  synchronous, active-high reset.
- req  input  4  per-port request, level; held high until ack is seen, then dropped.
- ack  output  4  per-port acknowledge; at most one bit high (one-hot or zero).
- grant_id  output  2  index of the currently or last granted port.
- busy  output  1  high in any state other than IDLE.
- port_reset  output  4  one-cycle abort pulse to the timed-out port.

Behaviour:
- Reset values: ack=0, grant_id=0, busy=0, port_reset=0, rr_ptr=0, hold_cnt=0, state=IDLE.
- Reset is synchronous. hard_reset high in any state returns the block to reset values on the next edge and overrides every other event, including an active grant.
- States: IDLE, GRANT, RELEASE, ABORT.
- IDLE:
  - If req != 0, choose winner w: the first set bit scanning from rr_ptr upward, mod 4.
  - Next edge: state=GRANT, ack[w]=1, grant_id=w, hold_cnt=0.
  - Latency from req sampled high to ack high is 1 cycle.
- GRANT:
  - Each cycle req[w]=1: hold_cnt increments, saturating at 2^CNT_W-1.
  - req[w] sampled 0: next edge ack=0, state=RELEASE.
  - If HOLD_MAX!=0, hold_cnt==HOLD_MAX-1 and req[w] still 1: next edge ack=0, port_reset[w]=1 for exactly one cycle, state=ABORT.
  - Changes on other req bits are ignored.
- RELEASE:
  - One mandatory cycle with ack=0.
  - rr_ptr=(w+1) mod 4, then IDLE.
  - No new grant is possible in this cycle, so back-to-back grants are spaced by at least 1 idle-ack cycle.
- ABORT:
  - Wait with ack=0 until req[w] is sampled 0.
  - Then rr_ptr=(w+1) mod 4, state=IDLE.
  - A port that never drops req blocks the responder; this is intentional.
- Simultaneous requests: round-robin only; no port can be granted twice in a row while another port is requesting.
- req dropping in the same cycle ack rises is legal and handled as a normal release on the next GRANT sample.
- busy is a registered decode of state != IDLE.
- grant_id holds its last value in IDLE.

Optional Feature:
- Macro: CROSSBAR_RESP_STATS_EN.
- Defined:
  - Adds output grant_cnt (4*CNT_W bits); slice i counts completed grants of port i.
  - A count increments on entry to RELEASE only; aborts are not counted.
  - Counts saturate and clear on hard_reset.
  - Adds output abort_cnt (CNT_W bits), counting ABORT entries.
- Not defined: neither port exists and no counter logic is generated; all other behaviour is identical.

Test Plan:
- Reset: hard_reset high 4 cycles with req=4'b1111 -> ack=0, busy=0, port_reset=0 throughout; on the first cycle after release, ack stays 0 and ack becomes 4'b0001 one cycle later.
- Single port, req=4'b0100 for 5 cycles then 0 -> ack=4'b0100 from cycle 1, ack=0 one cycle after req drops, grant_id=2, busy low 2 cycles after req drop.
- Fairness, req=4'b1111 held, each port drops req 3 cycles after its ack -> grant order 0,1,2,3,0 with at least one ack=0 cycle between grants.
- Timeout, HOLD_MAX=8, req[1] held forever -> ack[1] high exactly 8 cycles, then port_reset=4'b0010 for 1 cycle, ack=0, busy stays 1; drop req[1] -> IDLE next edge, next grant goes to port 2 if requested.
- Reset mid-grant: hard_reset asserted while ack=4'b1000 -> ack=0 on next edge, rr_ptr=0, so with req=4'b1001 after reset the next grant goes to port 0.
- With CROSSBAR_RESP_STATS_EN: 3 completed grants on port 0 and 1 abort on port 3 -> grant_cnt slice0=3, slice3=0, abort_cnt=1.
